// File: rtl/sopc_mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency RAM
// between the instruction-fetch and data ports.
module sopc_mem_arbiter #(
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_sel,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              stallreq,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [3:0]        mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] LAT_C = CW'(LATENCY);
  localparam logic [1:0] OWN_I = 2'b01;
  localparam logic [1:0] OWN_D = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACK
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [1:0]    owner;
  logic          last;
  logic [CW-1:0] cnt;
  logic          gnt_i;
  logic          gnt_d;
  logic          done;

  assign done = (cnt == LAT_C);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // last=0 means I was served last, so D wins a tie
  always_comb begin
    next_state = state;
    gnt_i      = 1'b0;
    gnt_d      = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_req && d_req) begin
          gnt_d = ~last;
          gnt_i = last;
        end else begin
          gnt_i = i_req;
          gnt_d = d_req;
        end
        if (gnt_i || gnt_d) next_state = BUSY;
      end
      BUSY: if (done) next_state = ACK;
      ACK:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= '0;
      last      <= 1'b0;
      cnt       <= '0;
      mem_ce    <= 1'b0;
      mem_we    <= 1'b0;
      mem_sel   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else if (gnt_i) begin
      owner     <= OWN_I;
      last      <= 1'b0;
      cnt       <= CW'(1);
      mem_ce    <= 1'b1;
      mem_we    <= 1'b0;
      mem_sel   <= 4'b1111;
      mem_addr  <= i_addr;
      mem_wdata <= '0;
    end else if (gnt_d) begin
      owner     <= OWN_D;
      last      <= 1'b1;
      cnt       <= CW'(1);
      mem_ce    <= 1'b1;
      mem_we    <= d_we;
      mem_sel   <= d_sel;
      mem_addr  <= d_addr;
      mem_wdata <= d_wdata;
    end else if (state == BUSY) begin
      if (done) begin
        mem_ce <= 1'b0;
        if (!mem_we && owner == OWN_I) i_rdata <= mem_rdata;
        if (!mem_we && owner == OWN_D) d_rdata <= mem_rdata;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign i_ack    = (state == ACK) && (owner == OWN_I);
  assign d_ack    = (state == ACK) && (owner == OWN_D);
  assign stallreq = (i_req & ~i_ack) | (d_req & ~d_ack);

endmodule
